// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: RV32I IF stage holding the PC and the IF/ID register,
// with hazard stalls, EX redirects and a RUN/HALT fetch FSM.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] PC_LAST   = 32'd48,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_halted,
  output logic [15:0] fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, id_pc_q, id_pc_d, id_pc4_q, id_pc4_d, id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        past_end, advance, hold;
  assign past_end = pc_q > PC_LAST;
  assign hold     = stall && !redirect;
  assign advance  = !redirect && !stall && state_q == RUN && !past_end;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end
  always_comb begin
    state_d = redirect ? RUN :
              stall ? state_q :
              (state_q == RUN && past_end) ? HALT : state_q;
  end
  // Anything that is neither a hold nor a real fetch loads a bubble.
  always_comb begin
    pc_d       = redirect ? {redirect_target[31:2], 2'b00} : advance ? pc_q + 32'd4 : pc_q;
    id_pc_d    = hold ? id_pc_q : advance ? pc_q : '0;
    id_pc4_d   = hold ? id_pc4_q : advance ? pc_q + 32'd4 : '0;
    id_instr_d = hold ? id_instr_q : advance ? imem_instr : NOP_INSTR;
    id_valid_d = hold ? id_valid_q : advance;
    cnt_d      = advance ? cnt_q + 16'd1 : cnt_q;
  end
  always_comb begin
    fetch_halted = state_q == HALT;
  end
  assign imem_addr      = pc_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_instr    = id_instr_q;
  assign if_id_valid    = id_valid_q;
  assign fetch_count    = cnt_q;
endmodule
